// File: rtl/axil_initiator_pkg.sv
// ---------------------------------------------------------------------------
// axil_initiator_pkg
// Shared definitions for the AXI4-Lite initiator and the AXI-Lite target
// blocks that sit on the same bus:
//   state_t      one-hot FSM encoding of the initiator
//   RESP_*       AXI response codes (also used by the target blocks)
//   PROT_DEFAULT fixed protection attribute driven on AWPROT/ARPROT
// ---------------------------------------------------------------------------
package axil_initiator_pkg;

   typedef enum logic [5:0] {
      ST_IDLE  = 6'b000001,
      ST_WADDR = 6'b000010,
      ST_WRESP = 6'b000100,
      ST_RADDR = 6'b001000,
      ST_RDATA = 6'b010000,
      ST_RSP   = 6'b100000
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Unprivileged, secure, data access.
   localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_initiator.sv
// ---------------------------------------------------------------------------
// axil_initiator
// Converts a simple valid/ready command/response interface into single
// AXI4-Lite transactions, one outstanding at a time.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   cmd_*                  command in: write flag, address, write data, strobe
//   rsp_*                  response out: kind, read data, AXI response code
//   i_ctrl_aw*/w*/b*       AXI4-Lite write address / data / response channels
//   i_ctrl_ar*/r*          AXI4-Lite read address / data channels
//
// Every output is either a flop or a decode of flops; no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module axil_initiator
   import axil_initiator_pkg::*;
#(
   parameter int addrWidth        = 32,
   parameter int dataWidth        = 32,
   parameter int writeStrobeWidth = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   // command
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [addrWidth-1:0]        cmd_addr,
   input  logic [dataWidth-1:0]        cmd_wdata,
   input  logic [writeStrobeWidth-1:0] cmd_wstrb,
   // response
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_write,
   output logic [dataWidth-1:0]        rsp_rdata,
   output logic [1:0]                  rsp_resp,
   // AXI4-Lite write address
   output logic                        i_ctrl_awvalid,
   input  logic                        i_ctrl_awready,
   output logic [addrWidth-1:0]        i_ctrl_awaddr,
   output logic [2:0]                  i_ctrl_awprot,
   // AXI4-Lite write data
   output logic                        i_ctrl_wvalid,
   input  logic                        i_ctrl_wready,
   output logic [dataWidth-1:0]        i_ctrl_wdata,
   output logic [writeStrobeWidth-1:0] i_ctrl_wstrb,
   // AXI4-Lite write response
   input  logic                        i_ctrl_bvalid,
   output logic                        i_ctrl_bready,
   input  logic [1:0]                  i_ctrl_bresp,
   // AXI4-Lite read address
   output logic                        i_ctrl_arvalid,
   input  logic                        i_ctrl_arready,
   output logic [addrWidth-1:0]        i_ctrl_araddr,
   output logic [2:0]                  i_ctrl_arprot,
   // AXI4-Lite read data
   input  logic                        i_ctrl_rvalid,
   output logic                        i_ctrl_rready,
   input  logic [dataWidth-1:0]        i_ctrl_rdata,
   input  logic [1:0]                  i_ctrl_rresp
);

   state_t                        state;
   state_t                        state_d;

   logic [addrWidth-1:0]          lat_addr;
   logic [dataWidth-1:0]          lat_wdata;
   logic [writeStrobeWidth-1:0]   lat_wstrb;
   logic                          lat_write;
   logic                          aw_done;
   logic                          w_done;

   logic                          cmd_accept;
   logic                          aw_hs;
   logic                          w_hs;
   logic                          b_hs;
   logic                          ar_hs;
   logic                          r_hs;

   assign cmd_accept = cmd_valid && cmd_ready;
   assign aw_hs      = i_ctrl_awvalid && i_ctrl_awready;
   assign w_hs       = i_ctrl_wvalid  && i_ctrl_wready;
   assign b_hs       = i_ctrl_bvalid  && i_ctrl_bready;
   assign ar_hs      = i_ctrl_arvalid && i_ctrl_arready;
   assign r_hs       = i_ctrl_rvalid  && i_ctrl_rready;

   // Address, data and strobe come straight from the command latch, so they
   // cannot move while a valid is waiting for its ready.
   assign i_ctrl_awaddr = lat_addr;
   assign i_ctrl_araddr = lat_addr;
   assign i_ctrl_wdata  = lat_wdata;
   assign i_ctrl_wstrb  = lat_wstrb;
   assign i_ctrl_awprot = PROT_DEFAULT;
   assign i_ctrl_arprot = PROT_DEFAULT;
   assign rsp_write     = lat_write;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   // cmd_ready is a flop tracking "next state is IDLE" so that it reads 0
   // while reset_n is low and 1 from the first clock after release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b0;
      end else begin
         state     <= state_d;
         cmd_ready <= (state_d == ST_IDLE);
      end
   end

   // ------------------------------------------------------------------
   // Next state and decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d        = state;
      i_ctrl_awvalid = 1'b0;
      i_ctrl_wvalid  = 1'b0;
      i_ctrl_bready  = 1'b0;
      i_ctrl_arvalid = 1'b0;
      i_ctrl_rready  = 1'b0;
      rsp_valid      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd_accept) begin
               state_d = cmd_write ? ST_WADDR : ST_RADDR;
            end
         end
         ST_WADDR: begin
            // Each channel drops its valid once its own handshake is done;
            // move on only when both have completed (in either order).
            i_ctrl_awvalid = !aw_done;
            i_ctrl_wvalid  = !w_done;
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               state_d = ST_WRESP;
            end
         end
         ST_WRESP: begin
            i_ctrl_bready = 1'b1;
            if (i_ctrl_bvalid) begin
               state_d = ST_RSP;
            end
         end
         ST_RADDR: begin
            i_ctrl_arvalid = 1'b1;
            if (i_ctrl_arready) begin
               state_d = ST_RDATA;
            end
         end
         ST_RDATA: begin
            i_ctrl_rready = 1'b1;
            if (i_ctrl_rvalid) begin
               state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Command latch, per-channel done flags, response capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         lat_write <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= RESP_OKAY;
      end else begin
         if (cmd_accept) begin
            lat_addr  <= cmd_addr;
            lat_wdata <= cmd_wdata;
            lat_wstrb <= cmd_wstrb;
            lat_write <= cmd_write;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
         end
         if (aw_hs) begin
            aw_done <= 1'b1;
         end
         if (w_hs) begin
            w_done <= 1'b1;
         end
         // Error responses are reported as-is; no retry.
         if (b_hs) begin
            rsp_resp  <= i_ctrl_bresp;
            rsp_rdata <= '0;
         end
         if (r_hs) begin
            rsp_resp  <= i_ctrl_rresp;
            rsp_rdata <= i_ctrl_rdata;
         end
      end
   end

endmodule

// File: tb/tb_axil_initiator.sv
// ---------------------------------------------------------------------------
// tb_axil_initiator
// Directed bench for axil_initiator. A small AXI4-Lite responder with a
// 16-word memory and configurable ready delays / response codes answers the
// initiator; each scenario task drives commands and checks outputs against
// hand-computed values, sampling 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_axil_initiator;
   import axil_initiator_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;

   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   logic        i_ctrl_awvalid, i_ctrl_awready;
   logic [31:0] i_ctrl_awaddr;
   logic [2:0]  i_ctrl_awprot;
   logic        i_ctrl_wvalid, i_ctrl_wready;
   logic [31:0] i_ctrl_wdata;
   logic [3:0]  i_ctrl_wstrb;
   logic        i_ctrl_bvalid, i_ctrl_bready;
   logic [1:0]  i_ctrl_bresp;
   logic        i_ctrl_arvalid, i_ctrl_arready;
   logic [31:0] i_ctrl_araddr;
   logic [2:0]  i_ctrl_arprot;
   logic        i_ctrl_rvalid, i_ctrl_rready;
   logic [31:0] i_ctrl_rdata;
   logic [1:0]  i_ctrl_rresp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axil_initiator dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .i_ctrl_awvalid(i_ctrl_awvalid), .i_ctrl_awready(i_ctrl_awready),
      .i_ctrl_awaddr(i_ctrl_awaddr), .i_ctrl_awprot(i_ctrl_awprot),
      .i_ctrl_wvalid(i_ctrl_wvalid), .i_ctrl_wready(i_ctrl_wready),
      .i_ctrl_wdata(i_ctrl_wdata), .i_ctrl_wstrb(i_ctrl_wstrb),
      .i_ctrl_bvalid(i_ctrl_bvalid), .i_ctrl_bready(i_ctrl_bready),
      .i_ctrl_bresp(i_ctrl_bresp),
      .i_ctrl_arvalid(i_ctrl_arvalid), .i_ctrl_arready(i_ctrl_arready),
      .i_ctrl_araddr(i_ctrl_araddr), .i_ctrl_arprot(i_ctrl_arprot),
      .i_ctrl_rvalid(i_ctrl_rvalid), .i_ctrl_rready(i_ctrl_rready),
      .i_ctrl_rdata(i_ctrl_rdata), .i_ctrl_rresp(i_ctrl_rresp)
   );

   // ---------------- responder model ----------------
   int          aw_delay, w_delay, ar_delay;
   logic        b_hold;
   logic [1:0]  b_resp_cfg, r_resp_cfg;
   logic        rd_ovr;
   logic [31:0] rd_ovr_data;

   logic [31:0] mem [0:15];
   int          aw_cnt, w_cnt, ar_cnt;
   logic        aw_got, w_got;
   logic [31:0] aw_lat, wd_lat;
   logic [3:0]  ws_lat;
   logic        aw_have, w_have, wr_fire;
   logic [31:0] wa, wd;
   logic [3:0]  ws;

   always_comb begin
      i_ctrl_awready = i_ctrl_awvalid && (aw_cnt >= aw_delay);
      i_ctrl_wready  = i_ctrl_wvalid  && (w_cnt  >= w_delay);
      i_ctrl_arready = i_ctrl_arvalid && (ar_cnt >= ar_delay);
      aw_have = aw_got || (i_ctrl_awvalid && i_ctrl_awready);
      w_have  = w_got  || (i_ctrl_wvalid  && i_ctrl_wready);
      wa      = aw_got ? aw_lat : i_ctrl_awaddr;
      wd      = w_got  ? wd_lat : i_ctrl_wdata;
      ws      = w_got  ? ws_lat : i_ctrl_wstrb;
      wr_fire = aw_have && w_have && !i_ctrl_bvalid && !b_hold;
   end

   always @(posedge clk) begin
      if (reset_n && wr_fire) begin
         for (int i = 0; i < 4; i++) begin
            if (ws[i]) mem[wa[5:2]][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         aw_lat <= '0; wd_lat <= '0; ws_lat <= '0;
         i_ctrl_bvalid <= 1'b0; i_ctrl_bresp <= 2'b00;
         i_ctrl_rvalid <= 1'b0; i_ctrl_rdata <= '0; i_ctrl_rresp <= 2'b00;
      end else begin
         if (i_ctrl_awvalid && i_ctrl_awready) begin
            aw_got <= 1'b1; aw_lat <= i_ctrl_awaddr; aw_cnt <= 0;
         end else if (i_ctrl_awvalid) aw_cnt <= aw_cnt + 1;
         if (i_ctrl_wvalid && i_ctrl_wready) begin
            w_got <= 1'b1; wd_lat <= i_ctrl_wdata; ws_lat <= i_ctrl_wstrb; w_cnt <= 0;
         end else if (i_ctrl_wvalid) w_cnt <= w_cnt + 1;
         if (wr_fire) begin
            i_ctrl_bvalid <= 1'b1; i_ctrl_bresp <= b_resp_cfg;
            aw_got <= 1'b0; w_got <= 1'b0;
         end else if (i_ctrl_bvalid && i_ctrl_bready) i_ctrl_bvalid <= 1'b0;
         if (i_ctrl_arvalid && i_ctrl_arready) begin
            ar_cnt <= 0;
            i_ctrl_rvalid <= 1'b1;
            i_ctrl_rdata  <= rd_ovr ? rd_ovr_data : mem[i_ctrl_araddr[5:2]];
            i_ctrl_rresp  <= r_resp_cfg;
         end else begin
            if (i_ctrl_arvalid) ar_cnt <= ar_cnt + 1;
            if (i_ctrl_rvalid && i_ctrl_rready) i_ctrl_rvalid <= 1'b0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd,
                         output logic [1:0] rr, output logic rw);
      bit acc, got;
      rd = '0; rr = 2'b00; rw = 1'b0;
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         if (cmd_ready) acc = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && acc && !got; i++) begin
         if (rsp_valid) begin
            rd = rsp_rdata; rr = rsp_resp; rw = rsp_write; got = 1'b1;
         end
         tick();
      end
      rsp_ready = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL cmd_timeout addr=%h accepted=%0b got_rsp=%0b required=1", a, acc, got);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      aw_delay = 0; w_delay = 0; ar_delay = 0; b_hold = 1'b0;
      b_resp_cfg = RESP_OKAY; r_resp_cfg = RESP_OKAY; rd_ovr = 1'b0; rd_ovr_data = '0;
      #22;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if ({i_ctrl_awvalid, i_ctrl_wvalid, i_ctrl_bready, i_ctrl_arvalid, i_ctrl_rready} !== 5'b0)
         begin errors++; $display("FAIL rst_axi_ctrl got %b exp 00000", {i_ctrl_awvalid, i_ctrl_wvalid, i_ctrl_bready, i_ctrl_arvalid, i_ctrl_rready}); end
      checks++; if ({rsp_write, rsp_resp, rsp_rdata} !== 35'b0)
         begin errors++; $display("FAIL rst_rsp_regs got %b %b %h exp 0 00 0", rsp_write, rsp_resp, rsp_rdata); end
      checks++; if ({i_ctrl_awaddr, i_ctrl_wdata, i_ctrl_wstrb} !== 68'b0)
         begin errors++; $display("FAIL rst_latch got %h %h %h exp 0", i_ctrl_awaddr, i_ctrl_wdata, i_ctrl_wstrb); end
      checks++; if ({i_ctrl_awprot, i_ctrl_arprot} !== 6'b0)
         begin errors++; $display("FAIL prot got %b %b exp 000", i_ctrl_awprot, i_ctrl_arprot); end
      @(negedge clk); reset_n = 1'b1;
      tick();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_cmd_ready got %b exp 1", cmd_ready); end
   endtask

   task automatic test_write;
      // cycle 0: command accepted
      cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h155; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_c0_cmd_ready got %b exp 1", cmd_ready); end
      tick(); cmd_valid = 1'b0;
      // cycle 1
      checks++; if ({i_ctrl_awvalid, i_ctrl_wvalid} !== 2'b11) begin errors++; $display("FAIL wr_c1_valids got %b exp 11", {i_ctrl_awvalid, i_ctrl_wvalid}); end
      checks++; if ({i_ctrl_awaddr, i_ctrl_wdata, i_ctrl_wstrb} !== {32'h0, 32'h155, 4'hF})
         begin errors++; $display("FAIL wr_c1_payload got %h %h %h exp 0 155 f", i_ctrl_awaddr, i_ctrl_wdata, i_ctrl_wstrb); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_c1_cmd_ready got %b exp 0", cmd_ready); end
      tick();
      // cycle 2
      checks++; if ({i_ctrl_awvalid, i_ctrl_wvalid, i_ctrl_bready, rsp_valid} !== 4'b0010)
         begin errors++; $display("FAIL wr_c2_ctrl got %b exp 0010", {i_ctrl_awvalid, i_ctrl_wvalid, i_ctrl_bready, rsp_valid}); end
      checks++; if (mem[0] !== 32'h155) begin errors++; $display("FAIL wr_target_odata got %h exp 155", mem[0]); end
      tick();
      // cycle 3
      checks++; if ({rsp_valid, rsp_write, rsp_resp, i_ctrl_bready} !== 5'b11000)
         begin errors++; $display("FAIL wr_c3_rsp got v%b w%b r%b b%b exp v1 w1 r00 b0", rsp_valid, rsp_write, rsp_resp, i_ctrl_bready); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_c3_rdata got %h exp 0", rsp_rdata); end
      rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL wr_c4_idle got %b exp 01", {rsp_valid, cmd_ready}); end
   endtask

   task automatic test_readback;
      logic [31:0] rd; logic [1:0] rr; logic rw;
      do_cmd(1'b1, 32'h4, 32'h3FF, 4'hF, rd, rr, rw);
      checks++; if ({rw, rr} !== 3'b100) begin errors++; $display("FAIL rb_wr_rsp got w%b r%b exp w1 r00", rw, rr); end
      do_cmd(1'b0, 32'h4, 32'h0, 4'h0, rd, rr, rw);
      checks++; if ({rw, rr, rd} !== {1'b0, 2'b00, 32'h3FF}) begin errors++; $display("FAIL rb_rd_rsp got w%b r%b %h exp w0 r00 3ff", rw, rr, rd); end
      do_cmd(1'b1, 32'h8, 32'h11223344, 4'hF, rd, rr, rw);
      do_cmd(1'b1, 32'h8, 32'hAABBCCDD, 4'h5, rd, rr, rw);
      do_cmd(1'b0, 32'h8, 32'h0, 4'h0, rd, rr, rw);
      checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL rb_strobe got %h exp 11bb33dd", rd); end
      b_resp_cfg = RESP_DECERR;
      do_cmd(1'b1, 32'hFFFF_FFFC, 32'h1, 4'hF, rd, rr, rw);
      b_resp_cfg = RESP_OKAY;
      checks++; if ({rw, rr, rd} !== {1'b1, RESP_DECERR, 32'h0}) begin errors++; $display("FAIL wr_decerr got w%b r%b %h exp w1 r11 0", rw, rr, rd); end
   endtask

   task automatic test_split;
      w_delay = 3;
      cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'h5A5A; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      checks++; if ({i_ctrl_awvalid, i_ctrl_wvalid} !== 2'b11) begin errors++; $display("FAIL sp_c1 got %b exp 11", {i_ctrl_awvalid, i_ctrl_wvalid}); end
      for (int c = 2; c <= 4; c++) begin
         tick();
         checks++; if ({i_ctrl_awvalid, i_ctrl_wvalid, i_ctrl_bready} !== 3'b010)
            begin errors++; $display("FAIL sp_c%0d aw/w/b got %b exp 010", c, {i_ctrl_awvalid, i_ctrl_wvalid, i_ctrl_bready}); end
      end
      rsp_ready = 1'b1;
      tick();
      checks++; if ({i_ctrl_wvalid, i_ctrl_bready, rsp_valid} !== 3'b010) begin errors++; $display("FAIL sp_c5 got %b exp 010", {i_ctrl_wvalid, i_ctrl_bready, rsp_valid}); end
      tick();
      checks++; if ({i_ctrl_bready, rsp_valid, rsp_write} !== 3'b011) begin errors++; $display("FAIL sp_c6 got %b exp 011", {i_ctrl_bready, rsp_valid, rsp_write}); end
      tick(); rsp_ready = 1'b0;
      checks++; if ({rsp_valid, cmd_ready, i_ctrl_bready} !== 3'b010) begin errors++; $display("FAIL sp_c7 got %b exp 010", {rsp_valid, cmd_ready, i_ctrl_bready}); end
      checks++; if (mem[3] !== 32'h5A5A) begin errors++; $display("FAIL sp_target got %h exp 5a5a", mem[3]); end
      w_delay = 0;
   endtask

   task automatic test_stall;
      ar_delay = 3; r_resp_cfg = RESP_SLVERR; rd_ovr = 1'b1; rd_ovr_data = 32'hDEADBEEF;
      cmd_write = 1'b0; cmd_addr = 32'h10; cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         checks++; if ({i_ctrl_arvalid, i_ctrl_araddr, i_ctrl_rready, cmd_ready} !== {1'b1, 32'h10, 1'b0, 1'b0})
            begin errors++; $display("FAIL st_ar_c%0d got v%b a%h r%b c%b exp v1 a10 r0 c0", c, i_ctrl_arvalid, i_ctrl_araddr, i_ctrl_rready, cmd_ready); end
         tick();
      end
      checks++; if ({i_ctrl_arvalid, i_ctrl_rready, rsp_valid} !== 3'b010) begin errors++; $display("FAIL st_c5 got %b exp 010", {i_ctrl_arvalid, i_ctrl_rready, rsp_valid}); end
      tick();
      for (int c = 6; c <= 10; c++) begin
         checks++; if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready} !== {1'b1, 1'b0, RESP_SLVERR, 32'hDEADBEEF, 1'b0})
            begin errors++; $display("FAIL st_rsp_c%0d got v%b w%b r%b %h c%b exp v1 w0 r10 deadbeef c0", c, rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready); end
         tick();
      end
      rsp_ready = 1'b1;
      checks++; if ({rsp_valid, cmd_ready} !== 2'b10) begin errors++; $display("FAIL st_c11 got %b exp 10", {rsp_valid, cmd_ready}); end
      tick(); rsp_ready = 1'b0;
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL st_c12 got %b exp 01", {rsp_valid, cmd_ready}); end
      ar_delay = 0; r_resp_cfg = RESP_OKAY; rd_ovr = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd; logic [1:0] rr; logic rw;
      b_hold = 1'b1;
      cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h77; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      tick();
      checks++; if (i_ctrl_bready !== 1'b1) begin errors++; $display("FAIL rm_in_wresp got %b exp 1", i_ctrl_bready); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({i_ctrl_awvalid, i_ctrl_wvalid, i_ctrl_bready, i_ctrl_arvalid, i_ctrl_rready, rsp_valid, cmd_ready} !== 7'b0)
         begin errors++; $display("FAIL rm_async got %b exp 0000000", {i_ctrl_awvalid, i_ctrl_wvalid, i_ctrl_bready, i_ctrl_arvalid, i_ctrl_rready, rsp_valid, cmd_ready}); end
      checks++; if ({i_ctrl_awaddr, rsp_write} !== 33'b0) begin errors++; $display("FAIL rm_latch got %h %b exp 0 0", i_ctrl_awaddr, rsp_write); end
      b_hold = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      tick();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_rel_cmd_ready got %b exp 1", cmd_ready); end
      do_cmd(1'b0, 32'h4, 32'h0, 4'h0, rd, rr, rw);
      checks++; if ({rw, rr, rd} !== {1'b0, 2'b00, 32'h3FF}) begin errors++; $display("FAIL rm_next_cmd got w%b r%b %h exp w0 r00 3ff", rw, rr, rd); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_readback();
      test_split();
      test_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axil_initiator.md
AXIL_INITIATOR -- requirements
Module: axil_initiator

Interface
REQ-001 The block SHALL have parameter addrWidth, default 32, AXI address width.
REQ-002 The block SHALL have parameter dataWidth, default 32, AXI data width.
REQ-003 The block SHALL have parameter writeStrobeWidth, default 4, equal to dataWidth/8.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low. Ports: clk input 1, system clock; reset_n input 1, async active-low reset.
REQ-005 The command ports SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in addrWidth; cmd_wdata in dataWidth; cmd_wstrb in writeStrobeWidth.
REQ-006 The response ports SHALL be: rsp_valid out 1; rsp_ready in 1; rsp_write out 1 (kind of the completed command); rsp_rdata out dataWidth; rsp_resp out 2.
REQ-007 The AXI4-Lite initiator ports SHALL be: i_ctrl_awvalid out 1, i_ctrl_awready in 1, i_ctrl_awaddr out addrWidth, i_ctrl_awprot out 3; i_ctrl_wvalid out 1, i_ctrl_wready in 1, i_ctrl_wdata out dataWidth, i_ctrl_wstrb out writeStrobeWidth; i_ctrl_bvalid in 1, i_ctrl_bready out 1, i_ctrl_bresp in 2; i_ctrl_arvalid out 1, i_ctrl_arready in 1, i_ctrl_araddr out addrWidth, i_ctrl_arprot out 3; i_ctrl_rvalid in 1, i_ctrl_rready out 1, i_ctrl_rdata in dataWidth, i_ctrl_rresp in 2.

Function
REQ-008 The block SHALL keep at most one transaction outstanding.
REQ-009 The FSM SHALL be one-hot with states IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
REQ-010 cmd_ready SHALL be 1 only in IDLE; a cmd_valid&cmd_ready cycle SHALL latch addr, wdata, wstrb and write, and go to WADDR (write) or RADDR (read).
REQ-011 In WADDR, i_ctrl_awvalid and i_ctrl_wvalid SHALL both be asserted from the first cycle, one cycle after command acceptance.
REQ-012 In WADDR, each valid SHALL deassert independently the cycle after its own handshake; a done flag SHALL be kept per channel.
REQ-013 WADDR SHALL go to WRESP when both handshakes are complete, including when both complete in the same cycle.
REQ-014 i_ctrl_bready SHALL be 1 only in WRESP; any bvalid seen in WADDR SHALL be ignored.
REQ-015 On the b handshake, the block SHALL capture bresp into rsp_resp, clear rsp_rdata to 0, and go to RSP.
REQ-016 In RADDR, i_ctrl_arvalid SHALL be 1; on the ar handshake the block SHALL go to RDATA.
REQ-017 i_ctrl_rready SHALL be 1 only in RDATA; on the r handshake the block SHALL capture rdata and rresp and go to RSP.
REQ-018 In RSP, rsp_valid SHALL be 1 with stable rsp_* values until rsp_ready; the cycle after the handshake the block SHALL return to IDLE.
REQ-019 Every AXI valid SHALL stay asserted, with address/data/strobe stable, until its handshake; it SHALL never be withdrawn.
REQ-020 i_ctrl_awprot and i_ctrl_arprot SHALL be constant 3'b000.
REQ-021 Addresses SHALL pass through unmodified, with no alignment or range checking.
REQ-022 SLVERR/DECERR responses SHALL be reported through rsp_resp without retry.
REQ-023 Minimum write latency SHALL be: accept in cycle 0, aw/w handshake in cycle 1, b handshake in cycle 2, rsp_valid in cycle 3. Reads SHALL follow the same timing.
REQ-024 All outputs SHALL be registered or decoded directly from the state register, with no combinational input-to-output path.

Reset
REQ-025 Asserting reset_n low SHALL, asynchronously and even mid-transaction, force state IDLE and set every valid/ready output to 0. Reset values: cmd_ready=1 after release, rsp_valid=0, rsp_resp=2'b00, rsp_rdata=0, rsp_write=0, latched address/data/strobe=0, done flags=0.

Structure
REQ-026 A shared package SHALL hold the state encodings and the AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; the AXI target blocks SHALL reuse the response constants.
REQ-027 The block SHALL be a single module with no sub-modules.

Verification
REQ-028 Write with the PIO target as responder: cmd write addr 0x0, wdata 0x155, wstrb 0xF -> awvalid and wvalid in cycle 1, target odata=0x155, rsp_valid in cycle 3 with rsp_resp=00, rsp_write=1.
REQ-029 Read-back: write 0x3FF to 0x4, then read 0x4 -> rsp_rdata=0x3FF, rsp_resp=00, rsp_write=0.
REQ-030 Split handshake: responder model asserts awready in cycle 1 and wready in cycle 4 -> awvalid low from cycle 2, wvalid high through cycle 4, single bready window, one response.
REQ-031 Stalls: arready delayed 3 cycles, then rresp=SLVERR with rdata 0xDEADBEEF and rsp_ready held low 5 cycles -> arvalid and araddr stable throughout, rsp stable until accepted, cmd_ready low until the cycle after the rsp handshake.
REQ-032 Reset mid-operation: reset_n low while in WRESP -> all valids and readies 0 immediately; after release, cmd_ready=1 and the next command completes normally.
